// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the timer controller slice.
//   state_t        - sequencer states (IDLE, ARM, RUN)
//   ADDR_*         - register write-port addresses
//   CTRL_*         - bit positions inside the CTRL register
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_RELOAD  = 2'd1;
    localparam logic [1:0] ADDR_COMPARE = 2'd2;
    localparam logic [1:0] ADDR_IRQ_CLR = 2'd3;

    localparam int unsigned CTRL_PS_LSB      = 0;
    localparam int unsigned CTRL_PS_MSB      = 2;
    localparam int unsigned CTRL_EDGE_BIT    = 3;
    localparam int unsigned CTRL_ONESHOT_BIT = 4;

    localparam int unsigned IRQ_CLR_OVF_BIT = 0;
    localparam int unsigned IRQ_CLR_CMP_BIT = 1;

endpackage

// File: rtl/timer_regfile.sv
// timer_regfile: pending (shadow) and active configuration registers.
//   i_clk, i_rst_n        clock, async active-low reset
//   i_wr_en/addr/data     register write port; writes land in pending regs
//   i_commit              copy pending -> active on the next edge
//   o_ps, o_edge_mode     active prescaler select / edge mode
//   o_one_shot            active one-shot enable
//   o_reload, o_compare   active reload / compare values
module timer_regfile
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_addr,
    input  logic [CNT_W-1:0] i_wr_data,
    input  logic             i_commit,
    output logic [2:0]       o_ps,
    output logic             o_edge_mode,
    output logic             o_one_shot,
    output logic [CNT_W-1:0] o_reload,
    output logic [CNT_W-1:0] o_compare
);

    logic [2:0]       r_ps_pend;
    logic             r_edge_pend;
    logic             r_os_pend;
    logic [CNT_W-1:0] r_reload_pend;
    logic [CNT_W-1:0] r_cmp_pend;

    logic [2:0]       r_ps;
    logic             r_edge;
    logic             r_one_shot;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_compare;

    // A commit copies the pending values as they stood before this edge;
    // a write arriving on the same edge waits for the following commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ps_pend     <= '0;
            r_edge_pend   <= 1'b0;
            r_os_pend     <= 1'b0;
            r_reload_pend <= '1;
            r_cmp_pend    <= '1;
            r_ps          <= '0;
            r_edge        <= 1'b0;
            r_one_shot    <= 1'b0;
            r_reload      <= '1;
            r_compare     <= '1;
        end else begin
            if (i_commit) begin
                r_ps       <= r_ps_pend;
                r_edge     <= r_edge_pend;
                r_one_shot <= r_os_pend;
                r_reload   <= r_reload_pend;
                r_compare  <= r_cmp_pend;
            end
            if (i_wr_en) begin
                case (i_wr_addr)
                    ADDR_CTRL: begin
                        r_ps_pend   <= i_wr_data[CTRL_PS_MSB:CTRL_PS_LSB];
                        r_edge_pend <= i_wr_data[CTRL_EDGE_BIT];
                        r_os_pend   <= i_wr_data[CTRL_ONESHOT_BIT];
                    end
                    ADDR_RELOAD:  r_reload_pend <= i_wr_data;
                    ADDR_COMPARE: r_cmp_pend    <= i_wr_data;
                    default: ;
                endcase
            end
        end
    end

    assign o_ps        = r_ps;
    assign o_edge_mode = r_edge;
    assign o_one_shot  = r_one_shot;
    assign o_reload    = r_reload;
    assign o_compare   = r_compare;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencer/config controller for the timer input stage.
//   clk, rst            clock, async active-low reset
//   wr_en/addr/data     register write port (CTRL, RELOAD, COMPARE, IRQ_CLR)
//   start, stop         level-sampled run control; stop wins over start
//   clk_pulse           single-cycle event from the input stage
//   ps, edge_mode       active prescaler select / edge mode to input stage
//   count               current event count
//   ovf_irq, cmp_irq    sticky overflow / compare flags (W1C via IRQ_CLR)
//   busy                high while in ARM or RUN
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             clk_pulse,
    output logic [2:0]       ps,
    output logic             edge_mode,
    output logic [CNT_W-1:0] count,
    output logic             ovf_irq,
    output logic             cmp_irq,
    output logic             busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_cmp;
    logic             r_busy;

    logic             w_one_shot;
    logic [CNT_W-1:0] w_reload;
    logic [CNT_W-1:0] w_compare;
    logic             w_commit;
    logic             w_pulse_run;
    logic             w_at_reload;
    logic             w_wrap;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_cmp_hit;
    logic             w_clr_wr;
    logic             w_clr_ovf;
    logic             w_clr_cmp;

    timer_regfile #(
        .CNT_W (CNT_W)
    ) u_regfile (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_commit    (w_commit),
        .o_ps        (ps),
        .o_edge_mode (edge_mode),
        .o_one_shot  (w_one_shot),
        .o_reload    (w_reload),
        .o_compare   (w_compare)
    );

    // A pulse only counts in RUN and only if stop is not asserted alongside.
    assign w_pulse_run = (r_state == RUN) && clk_pulse && !stop;
    assign w_at_reload = (r_count == w_reload);
    assign w_wrap      = w_pulse_run && w_at_reload;
    assign w_next_cnt  = w_at_reload ? '0 : r_count + CNT_W'(1);
    // Count never exceeds reload, so a compare above reload can never hit.
    assign w_cmp_hit   = w_pulse_run && (w_next_cnt == w_compare) &&
                         (w_compare <= w_reload);

    // Shadowed config follows writes freely in IDLE, loads once in ARM,
    // and otherwise only at a wrap so a running period is never disturbed.
    assign w_commit = (r_state == IDLE) || (r_state == ARM) || w_wrap;

    assign w_clr_wr  = wr_en && (wr_addr == ADDR_IRQ_CLR);
    assign w_clr_ovf = w_clr_wr && wr_data[IRQ_CLR_OVF_BIT];
    assign w_clr_cmp = w_clr_wr && wr_data[IRQ_CLR_CMP_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cmp   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    r_count <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (clk_pulse) begin
                        r_count <= w_next_cnt;
                        if (w_at_reload && w_one_shot) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Setting a flag takes priority over a same-cycle clear.
            if (w_wrap)
                r_ovf <= 1'b1;
            else if (w_clr_ovf)
                r_ovf <= 1'b0;

            if (w_cmp_hit)
                r_cmp <= 1'b1;
            else if (w_clr_cmp)
                r_cmp <= 1'b0;
        end
    end

    assign count   = r_count;
    assign ovf_irq = r_ovf;
    assign cmp_irq = r_cmp;
    assign busy    = r_busy;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench for timer_ctrl. A reference model steps at
// each rising edge and queues the outputs expected after that edge; a monitor
// pops and compares at the falling edge. Directed scenarios add explicit
// constant checks, followed by randomized traffic.
module tb_timer_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic             start;
    logic             stop;
    logic             clk_pulse;
    logic [2:0]       ps;
    logic             edge_mode;
    logic [CNT_W-1:0] count;
    logic             ovf_irq;
    logic             cmp_irq;
    logic             busy;

    timer_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .clk_pulse (clk_pulse),
        .ps        (ps),
        .edge_mode (edge_mode),
        .count     (count),
        .ovf_irq   (ovf_irq),
        .cmp_irq   (cmp_irq),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ps;
        int edm;
        int cnt;
        int ovf;
        int cmp;
        int busy;
    } exp_t;

    exp_t exp_q[$];

    // 0 = idle, 1 = arming, 2 = running
    int m_phase;
    int m_cnt, m_ovf, m_cmp;
    int p_ps, p_edm, p_os, p_reload, p_cmp;
    int a_ps, a_edm, a_os, a_reload, a_cmp;

    function automatic void m_reset();
        m_phase = 0; m_cnt = 0; m_ovf = 0; m_cmp = 0;
        p_ps = 0; p_edm = 0; p_os = 0; p_reload = 65535; p_cmp = 65535;
        a_ps = 0; a_edm = 0; a_os = 0; a_reload = 65535; a_cmp = 65535;
    endfunction

    function automatic void m_step(input bit s, input bit p, input bit pl,
                                   input bit we, input int adr, input int d);
        int  nphase;
        bit  wrap;
        bit  hit;
        nphase = m_phase;
        wrap   = 0;
        hit    = 0;
        if (m_phase == 0) begin
            if (s && !p) nphase = 1;
        end else if (m_phase == 1) begin
            m_cnt  = 0;
            nphase = 2;
        end else begin
            if (p) nphase = 0;
            else if (pl) begin
                if (m_cnt == a_reload) begin
                    m_cnt = 0;
                    wrap  = 1;
                    if (a_os != 0) nphase = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                hit = (m_cnt == a_cmp) && (a_cmp <= a_reload);
            end
        end
        if (m_phase != 2 || wrap) begin
            a_ps = p_ps; a_edm = p_edm; a_os = p_os;
            a_reload = p_reload; a_cmp = p_cmp;
        end
        if (we) begin
            case (adr)
                0: begin p_ps = d % 8; p_edm = (d / 8) % 2; p_os = (d / 16) % 2; end
                1: p_reload = d;
                2: p_cmp = d;
                default: ;
            endcase
        end
        if (wrap) m_ovf = 1;
        else if (we && adr == 3 && (d % 2) == 1) m_ovf = 0;
        if (hit) m_cmp = 1;
        else if (we && adr == 3 && ((d / 2) % 2) == 1) m_cmp = 0;
        m_phase = nphase;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst) m_reset();
        else m_step(start, stop, clk_pulse, wr_en, int'(wr_addr), int'(wr_data));
        e.ps = a_ps; e.edm = a_edm; e.cnt = m_cnt;
        e.ovf = m_ovf; e.cmp = m_cmp; e.busy = (m_phase != 0) ? 1 : 0;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            if (!rst) begin
                e.ps = 0; e.edm = 0; e.cnt = 0; e.ovf = 0; e.cmp = 0; e.busy = 0;
            end
            chk("sb_ps",   ps,        e.ps);
            chk("sb_edge", edge_mode, e.edm);
            chk("sb_count", count,    e.cnt);
            chk("sb_ovf",  ovf_irq,   e.ovf);
            chk("sb_cmp",  cmp_irq,   e.cmp);
            chk("sb_busy", busy,      e.busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit s, input bit p, input bit pl, input bit we,
                        input logic [1:0] a, input logic [CNT_W-1:0] d);
        start = s; stop = p; clk_pulse = pl; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clk_pulse = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [CNT_W-1:0] d);
        tick(0, 0, 0, 1, a, d);
    endtask

    task automatic pulse();
        tick(0, 0, 1, 0, 2'd0, '0);
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 2'd0, '0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ps"},    ps,        0);
        chk({tag, "_edge"},  edge_mode, 0);
        chk({tag, "_count"}, count,     0);
        chk({tag, "_ovf"},   ovf_irq,   0);
        chk({tag, "_cmp"},   cmp_irq,   0);
        chk({tag, "_busy"},  busy,      0);
    endtask

    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clk_pulse = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        all_zero("rst_init");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Wrap: reload=3 compare=2, five pulses
        wr(2'd1, 16'd3);
        wr(2'd2, 16'd2);
        wr(2'd0, 16'd0);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk("wrap_count", count, exp_wrap[i]);
            chk("wrap_cmp", cmp_irq, (i >= 1) ? 1 : 0);
            chk("wrap_ovf", ovf_irq, (i >= 3) ? 1 : 0);
        end
        tick(0, 1, 0, 0, 2'd0, '0);
        wr(2'd3, 16'd3);

        // One-shot with reload=1
        wr(2'd0, 16'h0010);
        wr(2'd1, 16'd1);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        pulse();
        chk("os_count1", count, 1);
        pulse();
        chk("os_count2", count, 0);
        chk("os_busy", busy, 0);
        pulse();
        chk("os_count3", count, 0);

        // Shadowed CTRL write while running
        wr(2'd0, 16'd0);
        wr(2'd1, 16'd3);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        pulse();
        wr(2'd0, 16'd5);
        idle();
        chk("shadow_ps_hold", ps, 0);
        pulse();
        pulse();
        chk("shadow_ps_hold2", ps, 0);
        pulse();
        chk("shadow_ps_commit", ps, 5);
        tick(0, 1, 0, 0, 2'd0, '0);

        // Conflicts
        tick(1, 1, 0, 0, 2'd0, '0);
        chk("startstop_busy", busy, 0);
        wr(2'd3, 16'd3);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        pulse();
        pulse();
        tick(0, 1, 1, 0, 2'd0, '0);
        chk("stop_pulse_busy", busy, 0);
        chk("stop_pulse_count", count, 2);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        pulse();
        pulse();
        pulse();
        tick(0, 0, 1, 1, 2'd3, 16'd1);
        chk("setclr_ovf", ovf_irq, 1);
        chk("setclr_count", count, 0);
        tick(0, 1, 0, 0, 2'd0, '0);

        // Ignored pulses and starts
        pulse();
        chk("idle_pulse_count", count, 0);
        tick(1, 0, 0, 0, 2'd0, '0);
        pulse();
        chk("arm_pulse_count", count, 0);
        pulse();
        chk("run_count1", count, 1);
        tick(1, 0, 0, 0, 2'd0, '0);
        chk("restart_busy", busy, 1);
        chk("restart_count", count, 1);
        pulse();
        chk("no_rearm_count", count, 2);
        tick(0, 1, 0, 0, 2'd0, '0);

        // Async reset mid-run at count=5
        wr(2'd1, 16'd100);
        tick(1, 0, 0, 0, 2'd0, '0);
        idle();
        for (int i = 0; i < 5; i++) pulse();
        chk("pre_rst_count", count, 5);
        rst = 1'b0;
        #1;
        all_zero("rst_run");
        idle();
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit               s, p, pl, we;
            logic [1:0]       a;
            logic [CNT_W-1:0] d;
            s  = ($urandom_range(0, 7) == 0);
            p  = ($urandom_range(0, 15) == 0);
            pl = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = CNT_W'($urandom_range(0, 31));
                2'd1:    d = CNT_W'($urandom_range(0, 7));
                2'd2:    d = CNT_W'($urandom_range(0, 9));
                default: d = CNT_W'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #1;
                all_zero("rst_rand");
                idle();
                rst = 1'b1;
            end else begin
                tick(s, p, pl, we, a, d);
            end
        end

        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
